// File: rtl/led_bank_arbiter_pkg.sv
// Shared definitions for the LED bank instruction arbiter.
// Optional build macro (used by led_bank_arbiter): LEDBANKARBITER_BURST_EN.
package led_bank_arbiter_pkg;

  localparam int unsigned INST_W = 12;
  localparam logic [3:0] OPCODE_LEGAL_MAX = 4'h9;

  typedef enum logic [1:0] {
    LEDBANKARBITER_State_Reset = 2'd0,
    LEDBANKARBITER_State_Ready = 2'd1,
    LEDBANKARBITER_State_Error = 2'd2
  } state_t;

  // Opcodes 0x0..0x9 are executable by the LED bank; anything above is illegal.
  function automatic logic opcode_legal(input logic [INST_W-1:0] inst);
    return inst[INST_W-1:INST_W-4] <= OPCODE_LEGAL_MAX;
  endfunction

endpackage

// File: rtl/led_bank_rr_pick.sv
// Combinational round-robin picker: first valid requester after ptr, with wrap.
module led_bank_rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned PW      = 2
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [PW-1:0]      ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [PW-1:0]      idx,
  output logic               any
);

  // Scan ptr+1, ptr+2, ... ptr+NUM_REQ (mod NUM_REQ); the first valid one wins.
  always_comb begin
    int unsigned cand;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = (32'(ptr) + k) % NUM_REQ;
      if (!any && valid[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        idx         = PW'(cand);
      end
    end
  end

endmodule

// File: rtl/led_bank_arbiter.sv
// Round-robin arbiter sharing the LED bank instruction port between requesters.
// Optional build macro: LEDBANKARBITER_BURST_EN (last grantee keeps priority
// for up to BURST_LEN consecutive transfers).
module led_bank_arbiter
  import led_bank_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned BURST_LEN = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_REQ*INST_W-1:0] req_inst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [INST_W-1:0]         inst,
  output logic                      inst_en,
  output logic                      error
);

  localparam int unsigned PW = $clog2(NUM_REQ);

  state_t              state, state_n;
  logic [PW-1:0]       last;
  logic [PW-1:0]       pick_ptr;
  logic [NUM_REQ-1:0]  pick_grant;
  logic [PW-1:0]       pick_idx;
  logic                pick_any;
  logic [INST_W-1:0]   sel_inst;
  logic                xfer;
  logic                legal;

`ifdef LEDBANKARBITER_BURST_EN
  logic [2:0]          burst_cnt;
  logic                burst_hold;

  // Holding priority is done by starting the search one slot before last.
  always_comb begin
    burst_hold = (burst_cnt != '0) && (32'(burst_cnt) < BURST_LEN) && req_valid[last];
    if (burst_hold)
      pick_ptr = (last == '0) ? PW'(NUM_REQ - 1) : last - PW'(1);
    else
      pick_ptr = last;
  end

  // Burst counter: counts consecutive transfers of the current grantee.
  always_ff @(posedge clock) begin
    if (reset)
      burst_cnt <= '0;
    else if (xfer)
      burst_cnt <= burst_hold ? burst_cnt + 3'd1 : 3'd1;
    else if (!req_valid[last])
      burst_cnt <= '0;
  end
`else
  assign pick_ptr = last;
`endif

  led_bank_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PW      (PW)
  ) u_pick (
    .valid (req_valid),
    .ptr   (pick_ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // Grant, selected instruction and next-state decode.
  always_comb begin
    req_ready = '0;
    sel_inst  = '0;
    state_n   = LEDBANKARBITER_State_Error;
    if (state == LEDBANKARBITER_State_Ready)
      req_ready = pick_grant;
    for (int unsigned i = 0; i < NUM_REQ; i++)
      if (pick_grant[i])
        sel_inst = req_inst[INST_W*i +: INST_W];
    xfer  = pick_any && (state == LEDBANKARBITER_State_Ready);
    legal = opcode_legal(sel_inst);
    case (state)
      LEDBANKARBITER_State_Reset: state_n = LEDBANKARBITER_State_Ready;
      LEDBANKARBITER_State_Ready: state_n = (xfer && !legal) ? LEDBANKARBITER_State_Error
                                                             : LEDBANKARBITER_State_Ready;
      LEDBANKARBITER_State_Error: state_n = LEDBANKARBITER_State_Error;
      default:                    state_n = LEDBANKARBITER_State_Error;
    endcase
  end

  // State, pointer and registered LED bank outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= LEDBANKARBITER_State_Reset;
      last    <= PW'(NUM_REQ - 1);
      inst    <= '0;
      inst_en <= 1'b0;
      error   <= 1'b0;
    end else begin
      state   <= state_n;
      inst_en <= xfer && legal;
      if (xfer)
        last <= pick_idx;
      if (state_n == LEDBANKARBITER_State_Error) begin
        inst  <= '0;
        error <= 1'b1;
      end else if (xfer && legal) begin
        inst <= sel_inst;
      end
    end
  end

endmodule

// File: tb/tb_led_bank_arbiter.sv
// Scoreboard bench for led_bank_arbiter against a queue-fed reference model.
module tb_led_bank_arbiter;

  localparam int NR = 4;
  localparam int BL = 4;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic [NR*12-1:0]  req_inst = '0;
  logic [NR-1:0]     req_valid = '0;
  logic [NR-1:0]     req_ready;
  logic [11:0]       inst;
  logic              inst_en;
  logic              error;

  led_bank_arbiter #(.NUM_REQ(NR), .BURST_LEN(BL)) dut (
    .clock     (clock),
    .reset     (reset),
    .req_inst  (req_inst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .inst      (inst),
    .inst_en   (inst_en),
    .error     (error)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [NR-1:0] ready;
    logic [11:0]   inst;
    logic          inst_en;
    logic          error;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  // Reference model: 0 = waiting after reset, 1 = arbitrating, 2 = error.
  int          m_mode  = 0;
  int          m_last  = NR - 1;
  int          m_cnt   = 0;
  logic [11:0] m_inst  = '0;
  logic        m_en    = 1'b0;
  logic        m_err   = 1'b0;
  bit          known   = 0;

  function automatic int model_pick(input logic [NR-1:0] v);
    if (m_mode != 1) return -1;
`ifdef LEDBANKARBITER_BURST_EN
    if (m_cnt != 0 && m_cnt < BL && v[m_last]) return m_last;
`endif
    for (int k = 1; k <= NR; k++)
      if (v[(m_last + k) % NR]) return (m_last + k) % NR;
    return -1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // One clock of stimulus: drive inputs, record the expectation, advance the model.
  task automatic step(input logic [NR-1:0] v, input logic [NR*12-1:0] d, input logic r);
    int   g;
    exp_t e;
    logic [11:0] w;
    @(posedge clock); #1;
    req_valid = v;
    req_inst  = d;
    reset     = r;
    g = model_pick(v);
    if (known) begin
      e.ready   = (g < 0) ? '0 : (NR'(1) << g);
      e.inst    = m_inst;
      e.inst_en = m_en;
      e.error   = m_err;
      exp_q.push_back(e);
    end
    if (r) begin
      m_mode = 0; m_last = NR - 1; m_cnt = 0;
      m_inst = '0; m_en = 1'b0; m_err = 1'b0;
      known  = 1;
    end else if (known) begin
      m_en = 1'b0;
      if (m_mode == 0) begin
        m_mode = 1;
      end else if (m_mode == 1) begin
        if (!v[m_last]) m_cnt = 0;
        if (g >= 0) begin
          w = d[12*g +: 12];
          m_cnt = (g == m_last && m_cnt != 0 && m_cnt < BL) ? m_cnt + 1 : 1;
          m_last = g;
          if (w[11:8] <= 4'h9) begin
            m_inst = w; m_en = 1'b1;
          end else begin
            m_mode = 2; m_inst = '0; m_err = 1'b1;
          end
        end
      end
    end
  endtask

  // Monitor: compare every observed cycle against the next queued expectation.
  always @(negedge clock) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("req_ready", 32'(req_ready), 32'(e.ready));
      chk("inst_en",   32'(inst_en),   32'(e.inst_en));
      chk("inst",      32'(inst),      32'(e.inst));
      chk("error",     32'(error),     32'(e.error));
    end
  end

  function automatic logic [NR*12-1:0] rand_insts(input int illegal_pct);
    logic [NR*12-1:0] d;
    logic [3:0] op;
    for (int i = 0; i < NR; i++) begin
      op = ($urandom_range(0, 99) < illegal_pct) ? 4'($urandom_range(10, 15))
                                                 : 4'($urandom_range(0, 9));
      d[12*i +: 12] = {op, 8'($urandom)};
    end
    return d;
  endfunction

  initial begin
    logic [NR*12-1:0] d;
    logic r;
    // Reset then idle.
    step('0, '0, 1'b1);
    step('0, '0, 1'b1);
    repeat (10) step('0, '0, 1'b0);
    // Single requester 2.
    d = '0; d[24 +: 12] = 12'h1A5;
    step(4'b0100, d, 1'b0);
    step('0, d, 1'b0);
    step('0, d, 1'b0);
    // Four-way contention.
    repeat (8) step(4'b1111, rand_insts(0), 1'b0);
    step('0, '0, 1'b0);
    // Two-way hold (burst pattern in the burst build, alternation otherwise).
    repeat (9) step(4'b0011, rand_insts(0), 1'b0);
    // Random legal traffic.
    repeat (200) step(4'($urandom), rand_insts(0), 1'b0);
    // Illegal opcode from requester 1, then requester 0 is locked out.
    d = '0; d[12 +: 12] = 12'hB00;
    step(4'b0010, d, 1'b0);
    d = '0; d[0 +: 12] = 12'h1FF;
    repeat (5) step(4'b0001, d, 1'b0);
    step('0, '0, 1'b1);
    step(4'b0001, d, 1'b0);
    step(4'b0001, d, 1'b0);
    step('0, '0, 1'b0);
    // Reset during contention.
    repeat (3) step(4'b1111, rand_insts(0), 1'b0);
    step(4'b1111, rand_insts(0), 1'b1);
    repeat (4) step(4'b1111, rand_insts(0), 1'b0);
    // Random traffic with occasional illegal opcodes and resets.
    repeat (400) begin
      r = ($urandom_range(0, 99) == 0) || (m_mode == 2 && $urandom_range(0, 5) == 0);
      step(4'($urandom), rand_insts(3), r);
    end
    step('0, '0, 1'b0);
    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clock);
    @(posedge clock);
    chk("drain", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/led_bank_arbiter.md
Name: led_bank_arbiter

Overview:
- Shares the single LED bank instruction port (12-bit inst, inst_en; opcode in inst[11:8], immediate in inst[7:0]) between NUM_REQ requesters.
- Each requester offers instructions on a valid/ready handshake. The arbiter grants round-robin, screens opcodes, and drives a registered inst/inst_en pair straight into the LED bank.
- Sits between the CPU/peripheral instruction sources and the LED bank.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..8.
- BURST_LEN, 4, maximum consecutive grants to one requester; used only with the optional feature.

Ports:
- clock  input  1  system clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- req_inst  input  NUM_REQ*12  requester i instruction at bits [12*i+11:12*i].
- req_valid  input  NUM_REQ  requester i offers an instruction.
- req_ready  output  NUM_REQ  one-hot grant; at most one bit high per cycle.
- inst  output  12  instruction to the LED bank.
- inst_en  output  1  inst is valid this cycle.
- error  output  1  sticky: an illegal opcode was accepted.

Behaviour:
- Clock and reset: one clock (clock). Reset is synchronous and active-high (reset). Reset overrides everything, including mid-transfer.
- Reset values: inst=0, inst_en=0, error=0, req_ready=0, state=RESET, last-grant pointer=NUM_REQ-1, so requester 0 has first priority.
- States:
  - RESET: req_ready=0. Next state READY after one cycle.
  - READY: arbitration active.
  - ERROR: absorbing; exits only via reset.
  - Any unencoded state value goes to ERROR.
- Arbitration in READY:
  - The search starts at (last+1) mod NUM_REQ and ascends with wrap. The first i with req_valid[i]=1 receives req_ready[i]=1.
  - req_ready is combinational from the current state, req_valid and the pointer. Requesters must not make req_valid depend on req_ready.
  - Transfer occurs when req_valid[i] & req_ready[i]. On transfer the pointer becomes i.
  - No valid requester: req_ready=0 and the pointer is unchanged.
- Forwarding:
  - A legal instruction (opcode 0x0..0x9) accepted in cycle N appears as inst=that value with inst_en=1 in cycle N+1. Latency is exactly 1 cycle.
  - With no transfer, inst_en=0 the next cycle and inst holds its previous value.
  - Throughput: one instruction per cycle. Back-to-back transfers from different requesters are allowed.
- Illegal opcode (0xA..0xF) accepted:
  - The instruction is not forwarded and inst_en=0 the next cycle.
  - error=1 from the next cycle; state moves to ERROR.
- ERROR state: req_ready=0, inst_en=0, inst=0, error=1.
- Timing rules:
  - A requester dropping req_valid before its grant loses nothing; no state is kept per requester.
  - Simultaneous valid requests are resolved solely by pointer order.
  - A single requester that stays valid is granted every cycle.

Optional Feature:
- Macro: LEDBANKARBITER_BURST_EN.
- Defined: a 3-bit burst counter is added.
  - While the last-granted requester keeps req_valid high, it keeps priority for up to BURST_LEN consecutive transfers. The counter increments per transfer.
  - At BURST_LEN, or on a grant to a different requester, the counter clears and the round-robin search resumes from last+1.
  - The counter resets to 0.
- Not defined: no counter; pure round-robin with one transfer per grant.
- Ports and latency are identical in both builds.

Decomposition:
- Shared package/header holds:
  - state encodings LEDBANKARBITER_State_Reset/Ready/Error (2 bits);
  - opcode-legal bound 4'h9;
  - the 12-bit instruction width constant.
- One natural sub-module, led_bank_rr_pick: combinational round-robin priority picker (inputs valid vector and pointer; outputs one-hot grant and index).

Test Plan:
- Reset then idle:
  - All outputs 0; req_ready=0 in the first post-reset cycle.
  - With no req_valid, inst_en stays 0 for 10 cycles.
- Single requester:
  - req_valid=4'b0100, req_inst[2]=12'h1A5.
  - req_ready=4'b0100 the same cycle; next cycle inst=12'h1A5, inst_en=1.
- Contention, burst disabled:
  - req_valid=4'b1111 held for 8 cycles.
  - Grants 0,1,2,3,0,1,2,3; inst_en high on 8 consecutive cycles.
- Illegal opcode:
  - Requester 1 sends 12'hB00.
  - inst_en=0 the next cycle and error=1 thereafter. Later valid 12'h1FF from requester 0 is never granted. Reset clears error.
- Reset mid-stream:
  - Assert reset during a 4-way contention.
  - Next cycle inst_en=0 and req_ready=0; the first grant after RESET goes to requester 0.
- Burst build (LEDBANKARBITER_BURST_EN, BURST_LEN=4):
  - req_valid=4'b0011 held.
  - Grants 0,0,0,0,1,1,1,1,0.
